mips_register_file: RTL and testbench
=====================================

# mips_register_file

MIPS general-purpose register file for the CPU datapath: 32 registers of 32 bits, two combinational read ports (rs, rt) and one synchronous write port (rd). Register r0 is hard-wired to zero. Register r2 ($v0) is exported continuously so the testbench and harness can observe the program result. Sits between the decode stage (read indices) and the writeback stage (write index and data).

## Interface
Parameters: none. Width 32 and depth 32 are fixed by the MIPS ISA.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset; clock clk
- rs_index  input  5  read port A register index
- rs_data  output  32  contents of register rs_index
- rt_index  input  5  read port B register index
- rt_data  output  32  contents of register rt_index
- rd_index  input  5  write port register index
- rd_data  input  32  write data
- write_enable  input  1  when 1, write rd_data to rd_index at the rising edge
- register_v0  output  32  contents of r2, continuous

## Operation
- Storage: 32 entries of 32 bits each, r0 to r31.
- Reset:
  - On a rising clk edge with reset=1, all 32 entries become 0x00000000.
  - Reset overrides write_enable; no write occurs in that cycle.
- Write:
  - On a rising edge with reset=0, write_enable=1 and rd_index≠0, the entry at rd_index takes rd_data.
  - write_enable=0 leaves all entries unchanged.
- r0:
  - A write to rd_index=0 is silently discarded.
  - r0 always reads 0x00000000.
- Reads:
  - rs_data and rt_data are purely combinational functions of the index and the array contents.
  - The two ports are independent and may address the same register.
  - Both ports may address the register being written.
- Reset override on reads: while reset=1, rs_data, rt_data and register_v0 are forced to 0x00000000, regardless of the array contents.
- register_v0 is always the current stored value of r2, subject to the reset override.
- No X values may propagate after the first reset edge.

## Timing
- Write latency: a write issued in cycle N is visible on the read ports and on register_v0 combinationally just after the rising edge that ends cycle N.
- Read latency: zero cycles. Output follows index changes within the same cycle.
- Same-cycle read of the register being written (no bypass build):
  - Before the edge, the read returns the old value.
  - After the edge, it returns rd_data.
- Reset asserted mid-sequence:
  - Outputs are 0 immediately while reset is high.
  - The array is zeroed at the next edge.
  - A pending write in that cycle is lost.
- Reset released: the array holds zeros until the first write.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding is enabled.
  - When reset=0, write_enable=1, rd_index≠0 and a read index equals rd_index, that port returns rd_data combinationally in the same cycle.
  - register_v0 likewise returns rd_data when rd_index=2.
- Undefined (default): no forwarding. Reads reflect stored contents only.
- Post-edge behaviour is identical in both builds.

## Test plan
- Reset: pulse reset=1 for one edge, then sweep rs_index and rt_index over 0..31 -> all reads 0x00000000 and register_v0 = 0.
- Write then read: write 0xDEADBEEF to r5, then set rs=5 and rt=5 -> both ports return 0xDEADBEEF after the edge. Write 0x12345678 to r2 -> register_v0 = 0x12345678.
- r0 protection: write_enable=1, rd_index=0, rd_data=0xFFFFFFFF -> reads of r0 stay 0.
- Write disable: write_enable=0, rd_index=7, rd_data=0xA5A5A5A5 -> r7 keeps its prior value.
- Reset priority: r9=0x11111111 stored, then reset=1 with a write of 0x22222222 to r9 in the same cycle -> outputs 0 during reset, and r9 reads 0 afterwards.
- Random regression: 100+ cycles of random indices, data and write_enable, with 1% reset probability -> every post-edge read matches a shadow model. With REGFILE_BYPASS_EN defined, same-cycle pre-edge reads of rd_index equal rd_data.

Source files
------------

// File: rtl/mips_register_file.sv
// MIPS 32x32 register file: two combinational read ports, one synchronous write port, r0 hard-wired to zero.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_index,
    output logic [31:0] rs_data,
    input  logic [4:0]  rt_index,
    output logic [31:0] rt_data,
    input  logic [4:0]  rd_index,
    input  logic [31:0] rd_data,
    input  logic        write_enable,
    output logic [31:0] register_v0
);

    logic [31:0][31:0] regs_q, regs_d;
    logic              wr_en;

    // r0 is never written, so after the first reset it stays zero in storage too
    assign wr_en = write_enable && (rd_index != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en)
            regs_d[rd_index] = rd_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            regs_q <= '0;
        else
            regs_q <= regs_d;
    end

    function automatic logic [31:0] read_port(input logic [4:0] idx);
        logic [31:0] val;
        val = regs_q[idx];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (idx == rd_index))
            val = rd_data;
`endif
        // Reset dominates everything, including the forwarded value
        if (reset || (idx == 5'd0))
            val = 32'h0000_0000;
        return val;
    endfunction

    always_comb begin
        rs_data     = read_port(rs_index);
        rt_data     = read_port(rt_index);
        register_v0 = read_port(5'd2);
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Randomized self-checking bench for mips_register_file against an array shadow model.
module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_index, rt_index, rd_index;
    logic [31:0] rs_data, rt_data, rd_data, register_v0;
    logic        write_enable;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    mips_register_file dut (
        .clk          (clk),
        .reset        (reset),
        .rs_index     (rs_index),
        .rs_data      (rs_data),
        .rt_index     (rt_index),
        .rt_data      (rt_data),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .write_enable (write_enable),
        .register_v0  (register_v0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] idx, input bit pre);
        if (reset) return 32'h0;
        if (idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (pre && write_enable && rd_index != 0 && rd_index == idx) return rd_data;
`endif
        return mdl[idx];
    endfunction

    task automatic cycle(input bit rst, input bit we, input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        reset = rst; write_enable = we; rd_index = rd; rd_data = d;
        rs_index = rs; rt_index = rt;
        #1;
        chk("rs_pre", rs_data, expect_rd(rs, 1'b1));
        chk("rt_pre", rt_data, expect_rd(rt, 1'b1));
        chk("v0_pre", register_v0, expect_rd(5'd2, 1'b1));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (we && rd != 0) begin
            mdl[rd] = d;
        end
        #1;
        chk("rs_post", rs_data, expect_rd(rs, 1'b0));
        chk("rt_post", rt_data, expect_rd(rt, 1'b0));
        chk("v0_post", register_v0, expect_rd(5'd2, 1'b0));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        reset = 1'b1; write_enable = 1'b0; rd_index = '0; rd_data = '0;
        rs_index = '0; rt_index = '0;

        // Reset pulse, then sweep both read ports across the array
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            cycle(0, 0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(31 - i));
            chk("sweep_rs_zero", rs_data, 32'h0);
        end

        // Write then read, and v0 export
        cycle(0, 1, 5, 32'hDEAD_BEEF, 5, 5);
        chk("r5_direct", rs_data, 32'hDEAD_BEEF);
        cycle(0, 1, 2, 32'h1234_5678, 2, 5);
        chk("v0_direct", register_v0, 32'h1234_5678);

        // r0 protection
        cycle(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        chk("r0_direct", rs_data, 32'h0);

        // Write disable keeps prior value
        cycle(0, 1, 7, 32'h0BAD_F00D, 7, 7);
        cycle(0, 0, 7, 32'hA5A5_A5A5, 7, 7);
        chk("r7_held", rt_data, 32'h0BAD_F00D);

        // Reset priority over a same-cycle write
        cycle(0, 1, 9, 32'h1111_1111, 9, 9);
        cycle(1, 1, 9, 32'h2222_2222, 9, 9);
        cycle(0, 0, 0, 0, 9, 2);
        chk("r9_after_rst", rs_data, 32'h0);

        // Random regression with ~1% reset probability
        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(99) == 0, $urandom_range(1), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom));
        end
        // Same-index read/write heavy phase
        for (int n = 0; n < 60; n++) begin
            logic [4:0] r;
            r = 5'($urandom);
            cycle(0, 1, r, $urandom, r, 5'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
